// File: rtl/spw_babasu_tx_port.sv
// spw_babasu_tx_port
//   Avalon-MM slave that buffers 9-bit SpaceWire TX characters written by the
//   CPU (bit 8 = control flag, bits 7:0 = data/control code) in a small FIFO
//   and presents them to the transmitter with a valid/ready handshake.
//
//   Optional feature macro: SPW_TX_PORT_IRQ_EN (drain interrupt, irq_mask
//   control bit, drained status bit). Without it those bits read 0.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   address[1:0]         register select (0 DATA, 1 STATUS, 2 CONTROL, 3 none)
//   write, writedata     single-cycle Avalon write
//   readdata[31:0]       registered read data, 1-cycle latency, no read strobe
//   tx_data[8:0]         FIFO head (0 when empty)
//   tx_valid, tx_ready   transmitter handshake; pop on tx_valid && tx_ready
//   irq                  drained && irq_mask, registered (feature build only)
module spw_babasu_tx_port #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [8:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`ifdef SPW_TX_PORT_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [8:0]    shadow;
  logic          enable, overflow;
  logic          drained, irq_mask;

  logic empty, full;
  logic wr_data, wr_stat, wr_ctrl, flush;
  logic pop, push_ok, ovf_set, drn_set;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  assign wr_data = write && (address == 2'd0);
  assign wr_stat = write && (address == 2'd1);
  assign wr_ctrl = write && (address == 2'd2);
  assign flush   = wr_ctrl && writedata[1];

  assign tx_valid = !empty && enable;
  assign tx_data  = empty ? 9'd0 : mem[rptr];

  // A flush wins over a pop in the same cycle: the pop is simply lost.
  assign pop     = tx_valid && tx_ready && !flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = wr_data && (!full || pop);
  assign ovf_set = wr_data && !push_ok;
  // Only a real pop of the last entry counts as a drain; a refill in the
  // same cycle keeps count at 1.
  assign drn_set = pop && !push_ok && (count == ONE_C);

  // Contents are never cleared; empty masks them on tx_data.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= writedata[8:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow   <= '0;
      enable   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) shadow <= writedata[8:0];
      if (wr_ctrl) enable <= writedata[0];
      // set has priority over a coincident clear
      if (ovf_set)                       overflow <= 1'b1;
      else if (wr_stat && writedata[18]) overflow <= 1'b0;
    end
  end

`ifdef SPW_TX_PORT_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drained  <= 1'b0;
      irq_mask <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) irq_mask <= writedata[2];
      if (drn_set)                       drained <= 1'b1;
      else if (wr_stat && writedata[19]) drained <= 1'b0;
      irq <= drained && irq_mask;
    end
  end
`else
  assign drained  = 1'b0;
  assign irq_mask = 1'b0;
  logic unused_drn;
  assign unused_drn = drn_set;
`endif

  logic unused_wd;
  assign unused_wd = ^writedata[31:9];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else begin
      case (address)
        2'd0:    readdata <= {23'd0, shadow};
        2'd1:    readdata <= {12'd0, drained, overflow, full, empty,
                              {(15-AW){1'b0}}, count};
        2'd2:    readdata <= {29'd0, irq_mask, 1'b0, enable};
        default: readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spw_babasu_tx_port.sv
module tb_spw_babasu_tx_port;

`ifdef SPW_TX_PORT_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam logic [31:0] DRN = IRQ ? 32'h80000 : 32'h0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [8:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
`ifdef SPW_TX_PORT_IRQ_EN
  logic        irq;
`endif

  spw_babasu_tx_port #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write),
    .writedata(writedata), .readdata(readdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef SPW_TX_PORT_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  a;
    logic        wr;
    logic [31:0] wd;
    logic        rdy;
    logic        ck;
    logic [31:0] rd;
    logic        vld;
    logic [8:0]  dat;
  } vec_t;

  vec_t tv[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // rd = readdata after the edge (state before the edge, at address a);
  // vld/dat = handshake outputs after the edge.
  task automatic add(input logic [1:0] a, input logic wr, input logic [31:0] wd,
                     input logic rdy, input logic ck, input logic [31:0] rd,
                     input logic vld, input logic [8:0] dat);
    vec_t v;
    v.a = a; v.wr = wr; v.wd = wd; v.rdy = rdy;
    v.ck = ck; v.rd = rd; v.vld = vld; v.dat = dat;
    tv.push_back(v);
  endtask

  task automatic step(input logic [1:0] a, input logic wr, input logic [31:0] wd,
                      input logic rdy);
    address = a; write = wr; writedata = wd; tx_ready = rdy;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [8:0] seq [8];
    seq[0] = 9'h002; seq[1] = 9'h003; seq[2] = 9'h004; seq[3] = 9'h005;
    seq[4] = 9'h006; seq[5] = 9'h007; seq[6] = 9'h008; seq[7] = 9'h055;

    // reset-state reads
    add(2'd2, 0, 0, 0, 1, 32'h1, 0, 9'h0);
    add(2'd1, 0, 0, 0, 1, 32'h10000, 0, 9'h0);
    add(2'd3, 0, 0, 0, 1, 32'h0, 0, 9'h0);
    // push three, then drain in order
    add(2'd0, 1, 32'h1A5, 0, 1, 32'h0,   1, 9'h1A5);
    add(2'd0, 1, 32'h0FF, 0, 1, 32'h1A5, 1, 9'h1A5);
    add(2'd0, 1, 32'h100, 0, 1, 32'h0FF, 1, 9'h1A5);
    add(2'd1, 0, 0, 0, 1, 32'h3, 1, 9'h1A5);
    add(2'd1, 0, 0, 1, 1, 32'h3, 1, 9'h0FF);
    add(2'd1, 0, 0, 1, 1, 32'h2, 1, 9'h100);
    add(2'd1, 0, 0, 1, 1, 32'h1, 0, 9'h0);
    add(2'd1, 0, 0, 0, 1, 32'h10000 | DRN, 0, 9'h0);
    add(2'd1, 1, 32'h80000, 0, 1, 32'h10000 | DRN, 0, 9'h0);
    add(2'd1, 0, 0, 0, 1, 32'h10000, 0, 9'h0);
    // fill past full: 9th push is rejected
    for (int i = 1; i <= 9; i++)
      add(2'd0, 1, i, 0, 1, (i == 1) ? 32'h100 : (i == 9 ? 32'h8 : i - 1), 1, 9'h001);
    add(2'd1, 0, 0, 0, 1, 32'h60008, 1, 9'h001);
    add(2'd0, 0, 0, 0, 1, 32'h8, 1, 9'h001);
    add(2'd1, 1, 32'h40000, 0, 1, 32'h60008, 1, 9'h001);
    add(2'd1, 0, 0, 0, 1, 32'h20008, 1, 9'h001);
    // push while full with a pop in the same cycle
    add(2'd0, 1, 32'h055, 1, 1, 32'h8, 1, 9'h002);
    add(2'd1, 0, 0, 0, 1, 32'h20008, 1, 9'h002);
    for (int j = 0; j < 8; j++)
      add(2'd1, 0, 0, 1, 1, (j == 0) ? 32'h20008 : 8 - j, j < 7, (j < 7) ? seq[j+1] : 9'h0);
    add(2'd1, 1, 32'h80000, 0, 1, 32'h10000 | DRN, 0, 9'h0);
    // enable off: pushes accepted, tx_valid held low
    add(2'd2, 1, 32'h0, 1, 1, 32'h1, 0, 9'h0);
    add(2'd0, 1, 32'h0AA, 1, 1, 32'h055, 0, 9'h0AA);
    add(2'd0, 1, 32'h0BB, 1, 1, 32'h0AA, 0, 9'h0AA);
    add(2'd1, 0, 0, 1, 1, 32'h2, 0, 9'h0AA);
    add(2'd2, 1, 32'h3, 1, 1, 32'h0, 0, 9'h0);
    add(2'd1, 0, 0, 1, 1, 32'h10000, 0, 9'h0);
    add(2'd2, 0, 0, 0, 1, 32'h1, 0, 9'h0);
    // flush coinciding with a pop: pop discarded, no drain
    add(2'd0, 1, 32'h033, 0, 1, 32'h0BB, 1, 9'h033);
    add(2'd2, 1, 32'h3, 1, 1, 32'h1, 0, 9'h0);
    add(2'd1, 0, 0, 0, 1, 32'h10000, 0, 9'h0);
    // address 3 writes ignored
    add(2'd3, 1, 32'hFFFFFFFF, 0, 1, 32'h0, 0, 9'h0);
    add(2'd2, 0, 0, 0, 1, 32'h1, 0, 9'h0);
    add(2'd1, 0, 0, 0, 1, 32'h10000, 0, 9'h0);
    add(2'd0, 0, 0, 0, 1, 32'h033, 0, 9'h0);

    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
    chk("rst_tx_data", {23'd0, tx_data}, 32'h0);
`ifdef SPW_TX_PORT_IRQ_EN
    chk("rst_irq", {31'd0, irq}, 32'h0);
`endif
    reset_n = 1'b1;
    step(2'd0, 0, 0, 0);
    chk("post_rst_readdata", readdata, 32'h0);

    foreach (tv[i]) begin
      step(tv[i].a, tv[i].wr, tv[i].wd, tv[i].rdy);
      if (tv[i].ck) chk($sformatf("v%0d_readdata", i), readdata, tv[i].rd);
      chk($sformatf("v%0d_tx_valid", i), {31'd0, tx_valid}, {31'd0, tv[i].vld});
      chk($sformatf("v%0d_tx_data", i), {23'd0, tx_data}, {23'd0, tv[i].dat});
    end

    // drain interrupt: irq follows drained one cycle later
    step(2'd2, 1, 32'h5, 0);
    step(2'd2, 0, 0, 0);
    chk("ctrl_mask_read", readdata, IRQ ? 32'h5 : 32'h1);
    step(2'd0, 1, 32'h011, 1);
    chk("irq_push_valid", {31'd0, tx_valid}, 32'h1);
    step(2'd1, 0, 0, 1);
    chk("irq_pop_empty", {31'd0, tx_valid}, 32'h0);
`ifdef SPW_TX_PORT_IRQ_EN
    chk("irq_lag", {31'd0, irq}, 32'h0);
`endif
    step(2'd1, 0, 0, 0);
    chk("irq_drained_stat", readdata, 32'h10000 | DRN);
`ifdef SPW_TX_PORT_IRQ_EN
    chk("irq_set", {31'd0, irq}, 32'h1);
`endif
    step(2'd1, 1, 32'h80000, 0);
    chk("irq_clr_stat_pre", readdata, 32'h10000 | DRN);
    step(2'd1, 0, 0, 0);
    chk("irq_clr_stat", readdata, 32'h10000);
`ifdef SPW_TX_PORT_IRQ_EN
    chk("irq_cleared", {31'd0, irq}, 32'h0);
    // irq_mask written 0 also drops irq
    step(2'd0, 1, 32'h022, 1);
    step(2'd1, 0, 0, 1);
    step(2'd1, 0, 0, 0);
    chk("irq_set2", {31'd0, irq}, 32'h1);
    step(2'd2, 1, 32'h1, 0);
    step(2'd2, 0, 0, 0);
    chk("irq_masked", {31'd0, irq}, 32'h0);
    chk("ctrl_unmasked", readdata, 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spw_babasu_tx_port.md
Name: spw_babasu_tx_port

Overview:
- Avalon-MM slave through which the Nios CPU feeds 9-bit SpaceWire TX characters: bit 8 is the control flag, bits 7:0 are the data or control code.
- It is the write-direction counterpart of the 9-bit read PIO. Writes are buffered in a small FIFO and presented to the SpaceWire transmitter with a valid/ready handshake.
- A status register exposes FIFO occupancy and errors so software can poll before writing.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- AW, 3, log2(DEPTH); count field width is AW+1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  Avalon register select
- write  in  1  Avalon write strobe, single cycle
- writedata  in  32  Avalon write data
- readdata  out  32  registered read data
- tx_data  out  9  head-of-FIFO character to SpaceWire TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data this cycle
- irq  out  1  drain interrupt (present only with the optional feature)

Behaviour:
- Reset and clocking: reset_n is asynchronous and active-low; clk is the clock. No clock enable; all state updates every clk.
- Values after reset: readdata=0, FIFO empty (count=0), enable=1, overflow=0, shadow=0, tx_valid=0, tx_data=0, irq=0.
- Register map (word addresses):
  - 0 DATA: a write pushes writedata[8:0]; a read returns {23'b0, shadow}, where shadow is the last accepted pushed word.
  - 1 STATUS: read returns count in [AW:0], empty in [16], full in [17], overflow in [18], drained in [19]. Writing 1 to bit 18 clears overflow; writing 1 to bit 19 clears drained.
  - 2 CONTROL: bit0 enable, bit1 flush (write-only, self-clearing, reads 0), bit2 irq_mask. Reads return {29'b0, irq_mask, 1'b0, enable}.
  - 3: reads 0; writes are ignored.
- readdata: loaded every cycle as readdata <= mux(address), independent of any read strobe. It therefore reflects state one clk after the address is presented (1-cycle read latency).
- Push: write to address 0. Accepted when not full, or when full and a pop occurs in the same cycle. A rejected push sets overflow (sticky) and leaves FIFO contents and shadow unchanged.
- Pop: occurs when tx_valid && tx_ready. tx_valid = !empty && enable. tx_data is the FIFO head, combinational from the storage array; it is 0 when empty.
- tx_data stability: tx_data must be held stable while tx_valid=1 and tx_ready=0.
- enable=0: gates tx_valid only. Pushes are still accepted.
- Simultaneous push and pop:
  - not empty: count unchanged, both pointers advance.
  - empty: no pop (tx_valid=0); the entry is written and count becomes 1.
- Pointers: AW bits, wrap from DEPTH-1 to 0. count is AW+1 bits and saturates logically at DEPTH (full). empty=(count==0), full=(count==DEPTH).
- Flush (CONTROL bit1=1): in the same write the FIFO pointers and count go to 0. A pop in that cycle is discarded. enable and irq_mask are also updated from that write. The FIFO contents are not cleared.
- drained: sets on the cycle count goes 1->0 through a pop; a flush does not set it. If a clear write and a set event coincide, set wins.
- overflow: if a clear write and a set event coincide, set wins.

Optional Feature:
- Macro: SPW_TX_PORT_IRQ_EN.
- Defined: irq port exists and is registered, irq <= drained && irq_mask. It deasserts the cycle after drained is cleared or irq_mask is written 0.
- Undefined: the irq port is absent, and CONTROL bit2 and STATUS bit19 read 0 and ignore writes.

Test Plan:
- Reset: hold reset_n=0, then release with tx_ready=0 -> readdata=0, tx_valid=0; a read of address 2 returns 0x1; a read of address 1 returns 0x10000 (empty).
- Push/pop order: write 0x1A5, 0x0FF, 0x100 to address 0 with tx_ready=0 -> STATUS count=3. Then raise tx_ready -> tx_data sequence is 0x1A5, 0x0FF, 0x100 on consecutive cycles, then tx_valid=0.
- Full/overflow: with tx_ready=0, push 9 words 0x001..0x009 into DEPTH=8 -> STATUS=0x60008 (full, overflow); address 0 reads 0x008. Write 0x40000 to address 1 -> overflow clears.
- Full with simultaneous push and pop: FIFO full, tx_ready=1, push 0x055 in the same cycle -> count stays 8, no overflow, and 0x055 emerges eighth after the current head.
- Enable/flush: write CONTROL=0x0, push 2 words with tx_ready=1 -> tx_valid stays 0. Write CONTROL=0x3 -> count=0, tx_valid=0, drained=0.
- IRQ (with SPW_TX_PORT_IRQ_EN): CONTROL=0x5, push one word, tx_ready=1 -> drained sets and irq=1 one cycle later. Write 0x80000 to address 1 -> irq=0.
